mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised successor of the fixed 4-bit counter: modulus-N up/down counter with enable, prescaler, synchronous clear/load, wrap or saturate mode, and a terminal-count pulse.
- Used as the general counting primitive for timers, dividers and sequencers across the design.
- One clock domain.

Parameters:
- WIDTH, 4: counter width in bits.
- MOD, 10: count range 0..MOD-1. Legal range 2 <= MOD <= 2**WIDTH; elaboration error otherwise.
- DIV, 1: prescale ratio. Count steps once per DIV enabled cycles. DIV >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- sat  in  1  mode: 1 = saturate at limit, 0 = wrap.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value to load.
- cnt  out  WIDTH  registered count value.
- tc  out  1  registered terminal-count pulse.

Behaviour:
- Reset (async, active-high): cnt=0, tc=0, prescaler=0. These hold while rst=1 regardless of the other inputs.
- Priority, each rising edge: rst > clr > load > step.
  - clr: cnt=0, prescaler=0, tc=0.
  - load: cnt=load_val, clamped to MOD-1 if load_val >= MOD. prescaler=0, tc=0.
- Prescaler:
  - Internal counter 0..DIV-1 advances only when en=1 and no clr/load.
  - tick=1 on an enabled cycle when prescaler==DIV-1; prescaler then returns to 0.
  - DIV=1: tick=en.
  - en=0 freezes the prescaler and cnt.
- Step on tick:
  - Up: cnt<MOD-1 -> cnt+1. cnt==MOD-1 -> 0 (sat=0) or hold MOD-1 (sat=1).
  - Down: cnt>0 -> cnt-1. cnt==0 -> MOD-1 (sat=0) or hold 0 (sat=1).
- tc: set for exactly one cycle, registered alongside cnt, after any tick taken with cnt at the limit for the current direction. Applies in both modes. In saturate mode tc repeats on every tick while pinned. tc=0 in all other cycles.
- up and sat are sampled at the tick. A direction change takes effect on the next tick with no extra latency.
- Latency: cnt and tc change one edge after the tick/clr/load cycle.
- Arithmetic is modulo MOD only. cnt never exceeds MOD-1.
- Reset mid-count: immediate clear, no partial prescale state is retained.

Optional Feature:
- Macro: MOD_COUNTER_OVF_STICKY_EN.
- Defined:
  - Adds ports ovf_clr (in, 1) and ovf (out, 1, registered).
  - ovf is set on any cycle that sets tc and held until ovf_clr=1, clr=1 or rst.
  - If set and ovf_clr occur in the same cycle, set wins.
  - Reset value 0.
- Undefined: both ports and the logic are absent. Core behaviour is unchanged.

Decomposition:
- Package counter_pkg:
  - Direction encodings DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Mode encodings MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Function clog2 for prescaler sizing.
- Sub-module counter_prescaler:
  - Parameter DIV.
  - Ports clk, rst, en, restart (driven by clr|load), tick.
  - Prescaler width clog2(DIV), minimum 1.

Test Plan (100 ns clock, WIDTH=4, MOD=10, DIV=1 unless noted):
1. Reset: rst=1 at 200 ns for 300 ns, asserted off-edge -> cnt=0 and tc=0 immediately. After release with en=1, up=1, sat=0 -> cnt 1..9, then 0 with tc=1 on that cycle only.
2. Down wrap and saturate: load 2, en=1, up=0, sat=0 -> 1,0,9 with tc at the 0->9 step. Repeat with sat=1 -> 1,0,0,0 with tc on each tick at 0.
3. Priority and clamping:
   - clr=1, load=1, load_val=5 same cycle -> cnt=0.
   - load_val=12 -> cnt=9.
   - load=1 with en=1 at cnt=9 -> no tc.
4. Prescaler, DIV=3: en=1 continuously -> cnt increments every 3rd cycle. Deassert en for 2 cycles mid-period -> period resumes where it stopped. load restarts the period.
5. Direction flip: at cnt=9 set up=0 with en=1 -> next value 8, no tc.
6. With MOD_COUNTER_OVF_STICKY_EN defined:
   - A wrap sets ovf and it stays 1 for 20 cycles.
   - ovf_clr asserted the same cycle as the next wrap -> ovf stays 1.
   - ovf_clr alone -> ovf=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2. Returns 0 for v <= 1, so callers clamp to a minimum width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: emits one tick per DIV enabled cycles. restart zeroes the
// phase so a clear or load always begins a full period.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("counter_prescaler: DIV must be >= 1");
        end
    endgenerate

    logic [PW-1:0] pcnt;

    // With DIV=1 LAST is 0 and pcnt never leaves 0, so tick follows en.
    assign tick = en & ~restart & (pcnt == LAST);

    // Phase counter: frozen while en=0, wraps at the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (restart) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulus-MOD up/down counter with prescaler, synchronous clear/load,
// wrap or saturate mode and a one-cycle terminal-count pulse.
// Optional sticky overflow flag (ports ovf_clr/ovf) is built only when
// MOD_COUNTER_OVF_STICKY_EN is defined.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

    generate
        if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
            $error("mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
        end
    endgenerate

    logic             tick;
    logic             at_lim;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_cl;

    counter_prescaler #(
        .DIV(DIV)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .restart(clr | load),
        .tick   (tick)
    );

    // Out-of-range loads are pinned to the top of the range.
    assign load_cl = ({1'b0, load_val} >= (WIDTH+1)'(MOD)) ? MAXV : load_val;

    // Limit depends on the direction sampled at this tick.
    assign at_lim = (up == DIR_UP) ? (cnt == MAXV) : (cnt == '0);

    // Next count for a tick: wrap or hold at the limit, else step by one.
    always_comb begin
        nxt = cnt;
        if (at_lim) begin
            if (sat == MODE_SAT) nxt = cnt;
            else                 nxt = (up == DIR_UP) ? '0 : MAXV;
        end else if (up == DIR_UP) begin
            nxt = cnt + WIDTH'(1);
        end else begin
            nxt = cnt - WIDTH'(1);
        end
    end

    // Count and terminal-count register; rst > clr > load > tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= load_cl;
            tc  <= 1'b0;
        end else if (tick) begin
            cnt <= nxt;
            tc  <= at_lim;
        end else begin
            tc  <= 1'b0;
        end
    end

`ifdef MOD_COUNTER_OVF_STICKY_EN
    // Sticky overflow: set by any tc-producing tick, which beats ovf_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (tick & at_lim) begin
            ovf <= 1'b1;
        end else if (ovf_clr | clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: DUT a (DIV=1) and DUT b (DIV=3) share
// stimulus; the driver queues hand-computed expectations, the monitor
// pops one entry per cycle and compares.
module tb_mod_counter;

    localparam int NC = -1;  // field not checked

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt_a, cnt_b;
    logic       tc_a, tc_b;
`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic       ovf_a, ovf_b;
`endif

    typedef struct {
        int    ca;
        int    ta;
        int    cb;
        int    tb;
        int    o;
        string tag;
    } exp_t;

    exp_t  q[$];
    string tag = "init";
    int    nvec = 0;
    int    nerr = 0;

    always #50 clk = ~clk;

    mod_counter #(.WIDTH(4), .MOD(10), .DIV(1)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(ovf_a),
`endif
        .cnt(cnt_a), .tc(tc_a)
    );

    mod_counter #(.WIDTH(4), .MOD(10), .DIV(3)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(ovf_b),
`endif
        .cnt(cnt_b), .tc(tc_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        if (exp >= 0) begin
            nvec++;
            if (act !== 32'(exp)) begin
                nerr++;
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
            end
        end
    endtask

    // Monitor: sample mid-low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #10;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, " cnt_a"}, {28'd0, cnt_a}, e.ca);
                chk({e.tag, " tc_a"},  {31'd0, tc_a},  e.ta);
                chk({e.tag, " cnt_b"}, {28'd0, cnt_b}, e.cb);
                chk({e.tag, " tc_b"},  {31'd0, tc_b},  e.tb);
`ifdef MOD_COUNTER_OVF_STICKY_EN
                chk({e.tag, " ovf_a"}, {31'd0, ovf_a}, e.o);
`endif
            end
        end
    end

    // One clock of stimulus; expectations describe outputs after the next edge.
    task automatic step(input logic c, input logic l, input logic [3:0] lv,
                        input logic e, input logic u, input logic s, input logic oc,
                        input int ca, input int ta, input int cb, input int tb,
                        input int o);
        @(negedge clk);
        #20;
        rst = 1'b0; clr = c; load = l; load_val = lv;
        en = e; up = u; sat = s; ovf_clr = oc;
        q.push_back('{ca, ta, cb, tb, o, tag});
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        #20;
        rst = 1'b1;
        q.push_back('{0, 0, 0, 0, 0, tag});
    endtask

    initial begin
        // Test 1: async reset at 200 ns, checked before any rising edge.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tag = "t1 reset async";
        q.push_back('{0, 0, 0, 0, 0, tag});
        tag = "t1 reset hold";
        rst_cycle();
        rst_cycle();
        tag = "t1 up wrap";
        for (int i = 1; i <= 9; i++) step(0,0,0, 1,1,0, 0, i,0, NC,NC, NC);
        step(0,0,0, 1,1,0, 0, 0,1, NC,NC, NC);
        step(0,0,0, 1,1,0, 0, 1,0, NC,NC, NC);
        tag = "t1 en freeze";
        step(0,0,0, 0,1,0, 0, 1,0, NC,NC, NC);

        // Test 2: down wrap then down/up saturate.
        tag = "t2 down wrap";
        step(0,1,4'd2, 1,0,0, 0, 2,0, NC,NC, NC);
        step(0,0,0, 1,0,0, 0, 1,0, NC,NC, NC);
        step(0,0,0, 1,0,0, 0, 0,0, NC,NC, NC);
        step(0,0,0, 1,0,0, 0, 9,1, NC,NC, NC);
        step(0,0,0, 1,0,0, 0, 8,0, NC,NC, NC);
        tag = "t2 down sat";
        step(0,1,4'd2, 1,0,1, 0, 2,0, NC,NC, NC);
        step(0,0,0, 1,0,1, 0, 1,0, NC,NC, NC);
        step(0,0,0, 1,0,1, 0, 0,0, NC,NC, NC);
        step(0,0,0, 1,0,1, 0, 0,1, NC,NC, NC);
        step(0,0,0, 1,0,1, 0, 0,1, NC,NC, NC);
        tag = "t2 up sat";
        step(0,1,4'd8, 1,1,1, 0, 8,0, NC,NC, NC);
        step(0,0,0, 1,1,1, 0, 9,0, NC,NC, NC);
        step(0,0,0, 1,1,1, 0, 9,1, NC,NC, NC);
        step(0,0,0, 1,1,1, 0, 9,1, NC,NC, NC);

        // Test 3: priority and clamping.
        tag = "t3 clr over load";
        step(1,1,4'd5, 1,1,0, 0, 0,0, NC,NC, NC);
        tag = "t3 clamp 12";
        step(0,1,4'd12, 0,1,0, 0, 9,0, NC,NC, NC);
        tag = "t3 wrap after clamp";
        step(0,0,0, 1,1,0, 0, 0,1, NC,NC, NC);
        tag = "t3 clamp 10";
        step(0,1,4'd10, 0,1,0, 0, 9,0, NC,NC, NC);
        tag = "t3 load at 9 no tc";
        step(0,1,4'd3, 1,1,0, 0, 3,0, NC,NC, NC);
        tag = "t3 clamp 15";
        step(0,1,4'd15, 0,1,0, 0, 9,0, NC,NC, NC);
        tag = "t3 clr at 9 no tc";
        step(1,0,0, 1,1,0, 0, 0,0, NC,NC, NC);

        // Test 5: direction flip at the limit.
        tag = "t5 flip at 9";
        step(0,1,4'd9, 0,1,0, 0, 9,0, NC,NC, NC);
        step(0,0,0, 1,0,0, 0, 8,0, NC,NC, NC);
        tag = "t5 flip at 0";
        step(0,1,4'd0, 0,0,0, 0, 0,0, NC,NC, NC);
        step(0,0,0, 1,1,0, 0, 1,0, NC,NC, NC);

        // Test 4: DIV=3 prescaler on DUT b.
        tag = "t4 clr";
        step(1,0,0, 1,1,0, 0, 0,0, 0,0, NC);
        tag = "t4 div3 run";
        step(0,0,0, 1,1,0, 0, NC,NC, 0,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 0,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 1,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 1,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 1,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 2,0, NC);
        tag = "t4 en gap";
        step(0,0,0, 1,1,0, 0, NC,NC, 2,0, NC);
        step(0,0,0, 0,1,0, 0, NC,NC, 2,0, NC);
        step(0,0,0, 0,1,0, 0, NC,NC, 2,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 2,0, NC);
        step(0,0,0, 1,1,0, 0, NC,NC, 3,0, NC);
        tag = "t4 load restart";
        step(0,0,0, 1,1,0, 0, NC,NC, 3,0, NC);
        step(0,1,4'd7, 1,1,0, 0, 7,0, 7,0, NC);
        step(0,0,0, 1,1,0, 0, 8,0, 7,0, NC);
        step(0,0,0, 1,1,0, 0, 9,0, 7,0, NC);
        step(0,0,0, 1,1,0, 0, 0,1, 8,0, NC);
        step(0,0,0, 1,1,0, 0, 1,0, 8,0, NC);
        tag = "t4 reset midcount";
        rst_cycle();
        step(0,0,0, 1,1,0, 0, 1,0, 0,0, 0);
        step(0,0,0, 1,1,0, 0, 2,0, 0,0, 0);
        step(0,0,0, 1,1,0, 0, 3,0, 1,0, 0);

`ifdef MOD_COUNTER_OVF_STICKY_EN
        // Test 6: sticky overflow on DUT a.
        tag = "t6 ovf set";
        step(0,1,4'd8, 1,1,0, 0, 8,0, NC,NC, 0);
        step(0,0,0, 1,1,0, 0, 9,0, NC,NC, 0);
        step(0,0,0, 1,1,0, 0, 0,1, NC,NC, 1);
        tag = "t6 ovf hold";
        for (int i = 0; i < 20; i++) step(0,0,0, 0,1,0, 0, 0,0, NC,NC, 1);
        tag = "t6 set beats ovf_clr";
        step(0,1,4'd9, 0,1,0, 0, 9,0, NC,NC, 1);
        step(0,0,0, 1,1,0, 1, 0,1, NC,NC, 1);
        tag = "t6 ovf_clr alone";
        step(0,0,0, 0,1,0, 1, 0,0, NC,NC, 0);
        step(0,0,0, 0,1,0, 0, 0,0, NC,NC, 0);
        tag = "t6 clr clears ovf";
        step(0,1,4'd9, 0,1,0, 0, 9,0, NC,NC, 0);
        step(0,0,0, 1,1,0, 0, 0,1, NC,NC, 1);
        step(1,0,0, 0,1,0, 0, 0,0, NC,NC, 0);
`endif

        // Drain: everything queued must have been consumed.
        step(0,0,0, 0,1,0, 0, NC,NC, NC,NC, NC);
        repeat (2) @(negedge clk);
        #15;
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
